ext_irq_sync: RTL and testbench

- Parametrised external-interrupt front end: per-channel synchronisation, optional glitch filtering, edge/level detection and pending latch.
- Sits between the SoC pads and the core-domain `interrupts_i` vector, replacing the tie-to-zero and the single-bit enable synchroniser.
- Generalises the 2-stage reset-to-0 synchroniser to N channels, with runtime-selectable trigger mode and software clear.

---
 rtl/ext_irq_sync_pkg.sv | 34 +++
 rtl/ext_irq_sync_debounce.sv | 57 +++++
 rtl/ext_irq_sync.sv | 95 +++++++++
 tb/tb_ext_irq_sync.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ext_irq_sync_pkg.sv
// Shared types and defaults for the external-interrupt front end.
// Trigger-mode encoding, debounce FSM states and the per-mode event rule live here.
package ext_irq_sync_pkg;

  localparam int unsigned NumExternalIrqs      = 4;
  localparam int unsigned ExtIrqSyncStages     = 2;
  localparam int unsigned ExtIrqDebounceCycles = 0;

  typedef enum logic [1:0] {
    IRQ_LEVEL = 2'b00,
    IRQ_RISE  = 2'b01,
    IRQ_FALL  = 2'b10,
    IRQ_BOTH  = 2'b11
  } irq_mode_e;

  typedef enum logic {
    DB_STABLE   = 1'b0,
    DB_COUNTING = 1'b1
  } db_state_e;

  // Event for one channel given the filtered level now and one cycle ago.
  function automatic logic irq_event(input irq_mode_e mode, input logic filt, input logic prev);
    logic evt;
    evt = 1'b0;
    unique case (mode)
      IRQ_LEVEL: evt = filt;
      IRQ_RISE:  evt = filt & ~prev;
      IRQ_FALL:  evt = ~filt & prev;
      IRQ_BOTH:  evt = filt ^ prev;
    endcase
    return evt;
  endfunction

endpackage

// File: rtl/ext_irq_sync_debounce.sv
// One channel of glitch filtering: filt follows s only after s has differed
// from filt for DebounceCycles consecutive cycles. Requires DebounceCycles >= 1.
module ext_irq_sync_debounce
  import ext_irq_sync_pkg::*;
#(
  parameter int unsigned DebounceCycles = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic s,
  output logic filt
);

  localparam int unsigned     CntW    = $clog2(DebounceCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

  db_state_e       state_q;
  logic [CntW-1:0] cnt_q;
  logic            filt_q;

  // The counter stops at CntLast and is cleared on every exit, so it never wraps.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= DB_STABLE;
      cnt_q   <= '0;
      filt_q  <= 1'b0;
    end else begin
      unique case (state_q)
        DB_STABLE: begin
          if (s != filt_q) begin
            if (CntLast == '0) begin
              filt_q <= ~filt_q;
            end else begin
              state_q <= DB_COUNTING;
              cnt_q   <= CntW'(1);
            end
          end
        end
        DB_COUNTING: begin
          if (s == filt_q) begin
            state_q <= DB_STABLE;
            cnt_q   <= '0;
          end else if (cnt_q == CntLast) begin
            filt_q  <= ~filt_q;
            state_q <= DB_STABLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign filt = filt_q;

endmodule

// File: rtl/ext_irq_sync.sv
// External-interrupt front end: per-channel synchroniser, optional debounce,
// edge/level event detection and a pending latch masked by enable.
module ext_irq_sync
  import ext_irq_sync_pkg::*;
#(
  parameter int unsigned NumIrqs        = NumExternalIrqs,
  parameter int unsigned SyncStages     = ExtIrqSyncStages,
  parameter int unsigned DebounceCycles = ExtIrqDebounceCycles
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic      [NumIrqs-1:0] irq_raw_i,
  input  logic      [NumIrqs-1:0] enable_i,
  input  irq_mode_e [NumIrqs-1:0] mode_i,
  input  logic      [NumIrqs-1:0] clear_i,
  output logic      [NumIrqs-1:0] level_o,
  output logic      [NumIrqs-1:0] pending_o,
  output logic      [NumIrqs-1:0] irq_o
);

  logic [NumIrqs-1:0] sync_q [SyncStages];
  logic [NumIrqs-1:0] s;
  logic [NumIrqs-1:0] filt;
  logic [NumIrqs-1:0] prev_q;
  logic [NumIrqs-1:0] evt;
  logic [NumIrqs-1:0] pending_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values. The synchroniser array is a flop chain, not a RAM, so it
  // is reset element by element like any other register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < SyncStages; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= irq_raw_i;
      for (int k = 1; k < SyncStages; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s = sync_q[SyncStages-1];

  if (DebounceCycles == 0) begin : g_bypass
    assign filt = s;
  end else begin : g_filter
    for (genvar i = 0; i < NumIrqs; i++) begin : g_ch
      ext_irq_sync_debounce #(
        .DebounceCycles(DebounceCycles)
      ) u_debounce (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .s     (s[i]),
        .filt  (filt[i])
      );
    end
  end

  // NOTE: evt gets a full default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    evt = '0;
    for (int i = 0; i < NumIrqs; i++) begin
      evt[i] = irq_event(mode_i[i], filt[i], prev_q[i]);
    end
  end

  // prev tracks filt regardless of mode so a mode switch never fabricates an edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= '0;
    end else begin
      prev_q <= filt;
    end
  end

  // Level mode mirrors the enabled line; edge modes latch until cleared, and a new event beats clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
    end else begin
      for (int i = 0; i < NumIrqs; i++) begin
        if (mode_i[i] == IRQ_LEVEL) begin
          pending_q[i] <= filt[i] & enable_i[i];
        end else if (evt[i] & enable_i[i]) begin
          pending_q[i] <= 1'b1;
        end else if (clear_i[i]) begin
          pending_q[i] <= 1'b0;
        end
      end
    end
  end

  assign level_o   = filt;
  assign pending_o = pending_q;
  assign irq_o     = pending_q & enable_i;

endmodule

// File: tb/tb_ext_irq_sync.sv
// Bench for ext_irq_sync: one bypass instance and one DebounceCycles=4 instance
// share stimulus and are checked every cycle against a run-length behavioural model.
module tb_ext_irq_sync;
  import ext_irq_sync_pkg::*;

  localparam int N  = 4;
  localparam int D4 = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic      [N-1:0] raw, en, clr;
  irq_mode_e [N-1:0] mode;
  logic      [N-1:0] lvl0, pend0, irq0, lvl4, pend4, irq4;

  int total = 0;
  int bad   = 0;

  ext_irq_sync #(.NumIrqs(N), .SyncStages(2), .DebounceCycles(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .irq_raw_i(raw), .enable_i(en), .mode_i(mode),
    .clear_i(clr), .level_o(lvl0), .pending_o(pend0), .irq_o(irq0)
  );

  ext_irq_sync #(.NumIrqs(N), .SyncStages(2), .DebounceCycles(D4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .irq_raw_i(raw), .enable_i(en), .mode_i(mode),
    .clear_i(clr), .level_o(lvl4), .pending_o(pend4), .irq_o(irq4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // ---------------- behavioural model ----------------
  // Synchronised line = raw delayed two clocks; the debounced line flips once it
  // has disagreed with the current level for D4 consecutive cycles.
  logic [N-1:0] m_s1 = '0, m_s = '0, m_f4 = '0;
  logic [N-1:0] m_prev0 = '0, m_prev4 = '0, m_pend0 = '0, m_pend4 = '0;
  int           m_run [N];

  function automatic logic [N-1:0] pend_next(input logic [N-1:0] f, input logic [N-1:0] p,
                                             input logic [N-1:0] pend, input logic [N-1:0] e,
                                             input logic [N-1:0] c, input irq_mode_e [N-1:0] md);
    logic [N-1:0] r;
    logic         hit;
    r = pend;
    for (int i = 0; i < N; i++) begin
      if (md[i] == IRQ_LEVEL) begin
        r[i] = f[i] & e[i];
      end else begin
        if (md[i] == IRQ_RISE)      hit = f[i] && !p[i];
        else if (md[i] == IRQ_FALL) hit = !f[i] && p[i];
        else                        hit = f[i] != p[i];
        if (hit && e[i])  r[i] = 1'b1;
        else if (c[i])    r[i] = 1'b0;
      end
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 <= '0; m_s <= '0; m_f4 <= '0;
      m_prev0 <= '0; m_prev4 <= '0; m_pend0 <= '0; m_pend4 <= '0;
      for (int i = 0; i < N; i++) m_run[i] <= 0;
    end else begin
      m_pend0 <= pend_next(m_s,  m_prev0, m_pend0, en, clr, mode);
      m_pend4 <= pend_next(m_f4, m_prev4, m_pend4, en, clr, mode);
      m_prev0 <= m_s;
      m_prev4 <= m_f4;
      for (int i = 0; i < N; i++) begin
        if (m_s[i] != m_f4[i]) begin
          if (m_run[i] + 1 >= D4) begin
            m_f4[i]  <= ~m_f4[i];
            m_run[i] <= 0;
          end else begin
            m_run[i] <= m_run[i] + 1;
          end
        end else begin
          m_run[i] <= 0;
        end
      end
      m_s  <= m_s1;
      m_s1 <= raw;
    end
  end

  always @(negedge clk) begin
    check("lvl0",  {28'd0, lvl0},  {28'd0, m_s});
    check("pend0", {28'd0, pend0}, {28'd0, m_pend0});
    check("irq0",  {28'd0, irq0},  {28'd0, m_pend0 & en});
    check("lvl4",  {28'd0, lvl4},  {28'd0, m_f4});
    check("pend4", {28'd0, pend4}, {28'd0, m_pend4});
    check("irq4",  {28'd0, irq4},  {28'd0, m_pend4 & en});
  end

  // ---------------- stimulus with literal pins ----------------
  initial begin
    raw = '0; en = '0; clr = '0;
    mode[0] = IRQ_RISE; mode[1] = IRQ_LEVEL; mode[2] = IRQ_BOTH; mode[3] = IRQ_FALL;
    repeat (2) @(posedge clk);
    #2;
    check("rst_outputs", {lvl0, pend0, irq0, lvl4, pend4, irq4}, 32'd0);
    rst_n = 1'b1;
    en    = '1;
    tick(3);

    // ch0 rise: bypass pending at edge 3, debounced level at 6 and pending at 7
    raw[0] = 1'b1;
    tick(2); check("d0_rise_e2", pend0[0], 1'b0);
    tick(1); check("d0_rise_e3", pend0[0], 1'b1);
    tick(2); check("d4_lvl_e5", lvl4[0], 1'b0);
    tick(1); check("d4_lvl_e6", lvl4[0], 1'b1);
    check("d4_pend_e6", pend4[0], 1'b0);
    tick(1); check("d4_pend_e7", pend4[0], 1'b1);
    clr[0] = 1'b1; tick(1); clr[0] = 1'b0;
    check("ch0_clear", {pend0[0], pend4[0]}, 2'b00);
    tick(5); check("ch0_no_reset", {pend0[0], pend4[0]}, 2'b00);

    // ch1 level: 3-cycle pulse is filtered, 10-cycle pulse gets through
    raw[1] = 1'b1; tick(3); raw[1] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      check("short_pulse", {lvl4[1], pend4[1]}, 2'b00);
    end
    raw[1] = 1'b1;
    tick(5); check("long_lvl_e5", lvl4[1], 1'b0);
    tick(1); check("long_lvl_e6", lvl4[1], 1'b1);
    check("long_irq_e6", irq4[1], 1'b0);
    tick(1); check("long_irq_e7", irq4[1], 1'b1);
    tick(3); raw[1] = 1'b0;
    tick(6); check("fall_lvl", lvl4[1], 1'b0);
    check("fall_pend_hold", pend4[1], 1'b1);
    tick(1); check("fall_irq", irq4[1], 1'b0);

    // ch2 both edges: set wins over a simultaneous clear
    raw[2] = 1'b1; tick(4); check("both_rise", pend0[2], 1'b1);
    clr[2] = 1'b1; tick(1); clr[2] = 1'b0;
    check("both_clear", pend0[2], 1'b0);
    raw[2] = 1'b0; tick(2);
    clr[2] = 1'b1; tick(1); clr[2] = 1'b0;
    check("set_wins", pend0[2], 1'b1);
    clr[2] = 1'b1; tick(1); clr[2] = 1'b0;
    check("extra_clear", pend0[2], 1'b0);

    // ch3 fall: dropped while disabled, latched while enabled, masked on irq only
    raw[3] = 1'b1; tick(8);
    en[3] = 1'b0; raw[3] = 1'b0; tick(8);
    check("fall_disabled", {pend0[3], pend4[3]}, 2'b00);
    en[3] = 1'b1; tick(2);
    check("fall_reenable", {pend0[3], pend4[3]}, 2'b00);
    raw[3] = 1'b1; tick(8); raw[3] = 1'b0; tick(8);
    check("fall_enabled", {pend0[3], pend4[3]}, 2'b11);
    en[3] = 1'b0; #1;
    check("mask_irq", {irq0[3], pend0[3]}, 2'b01);
    en[3] = 1'b1; #1;
    check("unmask_irq", irq0[3], 1'b1);
    tick(1);

    // mode switch level -> rise with ch0 held high
    clr = '1; tick(1); clr = '0;
    mode[0] = IRQ_LEVEL; tick(2);
    check("lvl_mode_pend", pend0[0], 1'b1);
    mode[0] = IRQ_RISE; tick(5);
    check("switch_keep", {pend0[0], pend4[0]}, 2'b11);
    clr[0] = 1'b1; tick(1); clr[0] = 1'b0; tick(5);
    check("switch_no_edge", {pend0[0], pend4[0]}, 2'b00);

    // reset mid-count (ch1 counter at 2), then release with all lines high
    raw[1] = 1'b1; tick(4);
    rst_n = 1'b0; #1;
    check("async_rst", {lvl0, pend0, irq0, lvl4, pend4, irq4}, 32'd0);
    tick(2);
    raw = '1; rst_n = 1'b1;
    tick(5); check("rel_lvl_e5", lvl4[0], 1'b0);
    tick(1); check("rel_lvl_e6", lvl4[0], 1'b1);
    tick(1); check("rel_rise", pend4[0], 1'b1);
    clr[0] = 1'b1; tick(1); clr[0] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      check("one_rise", pend4[0], 1'b0);
    end

    // randomized traffic, checked every cycle by the model
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 4) == 0) raw[i] = ~raw[i];
        clr[i] = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 31) == 0) mode[i] = irq_mode_e'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 15) == 0) en = N'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0; tick(1); rst_n = 1'b1;
      end
      tick(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
